uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter between up to eight byte producers, e.g. CPU store path, boot ROM printer and debug tracer. Each requester offers bytes over a valid/ready handshake. The block issues one byte at a time to the transmitter via a one-cycle enable pulse and tracks the transmitter's done flag. An optional packet lock holds the grant until a requester's last byte, so multi-byte messages are never interleaved.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- LOCK_TIMEOUT, 1023, idle cycles after which a held lock is dropped (0 = never drop)

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_valid_i  in  NUM_REQ  requester i has a byte
- req_data_i  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- req_last_i  in  NUM_REQ  byte ends requester i's packet
- req_ready_o  out  NUM_REQ  one-hot; byte of requester i accepted when valid&ready
- tx_data_o  out  8  byte to transmitter (registered)
- tx_en_o  out  1  one-cycle start pulse to transmitter (registered)
- tx_done_i  in  1  transmitter idle flag (high while idle, low while sending)
- busy_o  out  1  state != IDLE or lock held
- owner_o  out  3  index of last granted requester
- lock_o  out  1  packet lock held by owner_o

## Operation
State machine states are IDLE, WAIT_LOW and WAIT_HIGH.

**IDLE**
- Offer is made only when tx_done_i=1.
- If lock_o=1, only owner_o is eligible.
- Otherwise, pick the first valid requester starting at rr_ptr and wrapping modulo NUM_REQ.
- req_ready_o is one-hot on the chosen index, combinational from req_valid_i. Producers must not make valid depend on ready.
- On accept:
  - tx_data_o <= data.
  - tx_en_o <= 1.
  - owner_o <= idx.
  - lock_o <= !req_last_i[idx].
  - Go to WAIT_LOW.

**WAIT_LOW**
- tx_en_o <= 0 (pulse is exactly one cycle).
- Stay until tx_done_i=0, then go to WAIT_HIGH.
- The transmitter drops done two cycles after the accept edge. done must never be sampled as "finished" before it has been seen low.

**WAIT_HIGH**
- Stay until tx_done_i=1, then go to IDLE.
- If lock_o=0, rr_ptr <= owner_o+1 (wraps modulo NUM_REQ).

**Lock timeout**
- While lock_o=1 and in IDLE with req_valid_i[owner_o]=0, count idle cycles.
- When the count reaches LOCK_TIMEOUT: lock_o <= 0, rr_ptr <= owner_o+1, counter cleared.
- The counter clears on every accept.

**Other rules**
- req_ready_o is all-zero in WAIT_LOW, in WAIT_HIGH, while rst_ni=0, and whenever tx_done_i=0.
- Data bits of non-granted requesters are ignored.
- Reset may occur mid-byte. All state returns to reset values immediately. The transmitter may still be finishing a frame, so IDLE waits for tx_done_i=1 before the next offer.

## Timing
Reset values:
- State IDLE
- tx_en_o=0
- tx_data_o=0
- owner_o=0
- lock_o=0
- rr_ptr=0
- timeout counter=0
- busy_o=0

Latencies:
- Accept at edge k. tx_en_o is high in cycle k+1 only, and the transmitter samples it at edge k+1.
- Earliest next accept is the first IDLE cycle after tx_done_i returns high, so back-to-back bytes have zero idle bit-times.

Simultaneous events:
- All valid in the same cycle: grant follows rotation from rr_ptr.
- New valid during WAIT_*: held until IDLE.

## Structure
- Shared package uart_pkg holds the state encoding localparams (IDLE/WAIT_LOW/WAIT_HIGH), the byte width 8, and the maximum NUM_REQ 8.
- One sub-module, rr_pick: combinational rotate-priority picker. Inputs are a NUM_REQ request vector and a start pointer; output is a one-hot grant plus its encoded index.
- The timeout counter and FSM live in the top module.

## Test plan
Bench conditions: NUM_REQ=4, LOCK_TIMEOUT=16, and a transmitter model with BAUD_DIV=4 that reproduces the done timing.

1. **Single byte.** Requester 2 presents 0x41 with last=1 → one accept, tx_data_o=0x41, a single tx_en_o pulse one cycle later, busy_o back to 0 after done rises; lock_o stays 0.
2. **Round-robin.** All four requesters valid with last=1 continuously → grant order 0,1,2,3,0.
3. **Packet lock.** Req 1 sends 3 bytes 0x10,0x11,0x12 with last on the third, while req 0 and req 3 stay valid → all three req 1 bytes are sent consecutively, then req 3 is granted.
4. **Lock timeout.** Req 0 sends one byte with last=0, then drops valid for 16 cycles → lock_o falls, and pending req 2 is granted on the next cycle.
5. **done discipline.** Hold tx_done_i low externally while valid is asserted → req_ready_o stays 0. Also check that exactly one tx_en_o pulse occurs per accepted byte.
6. **Reset mid-byte.** Pulse rst_ni low during WAIT_HIGH → outputs take reset values, and no new accept occurs until tx_done_i is high.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: byte width, requester limit
// and the scheduler state encoding.
package uart_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = $clog2(MAX_REQ);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd1;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_WAIT_LOW  = ST_WAIT_LOW,
        S_WAIT_HIGH = ST_WAIT_HIGH
    } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after start_i,
// wrapping modulo N, returned one-hot and as an encoded index.
module rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] pos;
    logic [IDX_W:0]   sum;
    logic             found;

    always_comb begin
        rot   = N'({req_i, req_i} >> start_i);
        pos   = '0;
        found = 1'b0;
        // Descending scan so the lowest rotated position wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pos   = IDX_W'(k);
                found = 1'b1;
            end
        end
        sum = (IDX_W + 1)'(start_i) + (IDX_W + 1)'(pos);
        if (sum >= (IDX_W + 1)'(N)) begin
            sum = sum - (IDX_W + 1)'(N);
        end
        idx_o   = sum[IDX_W-1:0];
        grant_o = found ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// producers, with optional packet lock and idle-timeout lock release.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOCK_TIMEOUT = 1023
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [BYTE_W-1:0]         tx_data_o,
    output logic                      tx_en_o,
    input  logic                      tx_done_i,
    output logic                      busy_o,
    output logic [IDX_W-1:0]          owner_o,
    output logic                      lock_o
);

    localparam int unsigned CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    state_e             state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic               lock_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BYTE_W-1:0]  tx_data_q;
    logic               tx_en_q;

    logic [NUM_REQ-1:0] owner_mask;
    logic               owner_valid;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               offer;
    logic               accept;
    logic [BYTE_W-1:0]  sel_data;
    logic               sel_last;
    logic [IDX_W-1:0]   next_ptr;
    logic               idle_tick;
    logic               timeout_hit;

    // While locked only the owner may be offered a slot.
    always_comb begin
        owner_mask  = NUM_REQ'(1) << owner_q;
        owner_valid = |(req_valid_i & owner_mask);
        eligible    = lock_q ? (req_valid_i & owner_mask) : req_valid_i;
    end

    rr_pick #(
        .N       (NUM_REQ)
    ) u_pick (
        .req_i   (eligible),
        .start_i (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    always_comb begin
        offer       = (state_q == S_IDLE) && tx_done_i && rst_ni;
        req_ready_o = offer ? pick_grant : '0;
        accept      = offer && (|pick_grant);
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_grant[k]) begin
                sel_data = req_data_i[BYTE_W*k +: BYTE_W];
                sel_last = req_last_i[k];
            end
        end
    end

    // Idle cycles are counted only while the owner has nothing to send.
    always_comb begin
        next_ptr    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        idle_tick   = (LOCK_TIMEOUT != 0) && lock_q && (state_q == S_IDLE) && !owner_valid;
        timeout_hit = idle_tick && (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            lock_q    <= 1'b0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        tx_data_q <= sel_data;
                        tx_en_q   <= 1'b1;
                        owner_q   <= pick_idx;
                        lock_q    <= !sel_last;
                        cnt_q     <= '0;
                        state_q   <= S_WAIT_LOW;
                    end else if (timeout_hit) begin
                        lock_q   <= 1'b0;
                        rr_ptr_q <= next_ptr;
                        cnt_q    <= '0;
                    end else if (idle_tick) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // done must be seen low before its rise can mean "finished".
                S_WAIT_LOW: begin
                    if (!tx_done_i) begin
                        state_q <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (tx_done_i) begin
                        state_q <= S_IDLE;
                        if (!lock_q) begin
                            rr_ptr_q <= next_ptr;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_data_o = tx_data_q;
    assign tx_en_o   = tx_en_q;
    assign owner_o   = owner_q;
    assign lock_o    = lock_q;
    assign busy_o    = (state_q != S_IDLE) || lock_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter model, per-cycle behavioural model
// comparison and directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int LT       = 16;
    localparam int BAUD_DIV = 4;
    localparam int FRAME    = 10 * BAUD_DIV;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_last = '0;
    logic [8*N-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic [7:0]       tx_data;
    logic             tx_en;
    logic             tx_done;
    logic             busy;
    logic [2:0]       owner;
    logic             lock;
    logic             force_low = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_data_o   (tx_data),
        .tx_en_o     (tx_en),
        .tx_done_i   (tx_done),
        .busy_o      (busy),
        .owner_o     (owner),
        .lock_o      (lock)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter: done falls two edges after the accept edge, stays low FRAME cycles.
    int         tx_cnt = 0;
    bit         tx_pend = 1'b0;
    int         tx_overlap = 0;
    logic [7:0] tx_log[$];

    assign tx_done = (tx_cnt == 0) && !force_low;

    always @(posedge clk) begin
        if (tx_pend) begin
            tx_pend <= 1'b0;
            tx_cnt  <= FRAME;
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
        end
        if (tx_en) begin
            tx_pend <= 1'b1;
            tx_log.push_back(tx_data);
            if (tx_cnt != 0 || tx_pend) tx_overlap++;
        end
    end

    // Producers: entries {idx[3:0], last, data[7:0]}, per-requester FIFO order.
    logic [12:0] pq[$];
    logic [11:0] exp_q[$];
    logic [11:0] dut_log[$];
    int          checked = 0;

    task automatic push(input int idx, input bit last, input logic [7:0] d);
        pq.push_back({4'(idx), last, d});
    endtask

    task automatic expect_byte(input int idx, input logic [7:0] d);
        exp_q.push_back({4'(idx), d});
    endtask

    task automatic pop(input int idx);
        for (int j = 0; j < pq.size(); j++) begin
            if (int'(pq[j][12:9]) == idx) begin
                pq.delete(j);
                break;
            end
        end
    endtask

    task automatic refresh();
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [8*N-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < pq.size(); j++) begin
                if (int'(pq[j][12:9]) == i) begin
                    v[i] = 1'b1;
                    l[i] = pq[j][8];
                    d[8*i +: 8] = pq[j][7:0];
                    break;
                end
            end
        end
        req_valid = v;
        req_last  = l;
        req_data  = d;
    endtask

    always @(posedge clk) begin
        #1;
        refresh();
    end

    // Behavioural model of the scheduler.
    int         m_phase = 0;   // 0 idle, 1 waiting for done low, 2 waiting for done high
    int         m_rr = 0;
    int         m_owner = 0;
    int         m_cnt = 0;
    bit         m_lock = 1'b0;
    bit         m_en = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         acc_idx = -1;

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        r = '0;
        if (rst_n && m_phase == 0 && tx_done) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (req_valid[i] && (!m_lock || i == m_owner)) begin
                    r[i] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_rr = 0; m_owner = 0; m_cnt = 0;
            m_lock = 1'b0; m_en = 1'b0; m_data = 8'h00;
        end else begin
            m_en = 1'b0;
            if (m_phase == 0) begin
                if (acc_idx >= 0) begin
                    m_data  = req_data[8*acc_idx +: 8];
                    m_en    = 1'b1;
                    m_owner = acc_idx;
                    m_lock  = !req_last[acc_idx];
                    m_cnt   = 0;
                    m_phase = 1;
                    pop(acc_idx);
                end else if (m_lock && !req_valid[m_owner]) begin
                    m_cnt++;
                    if (m_cnt == LT) begin
                        m_lock = 1'b0;
                        m_rr   = (m_owner + 1) % N;
                        m_cnt  = 0;
                    end
                end
            end else if (m_phase == 1) begin
                if (!tx_done) m_phase = 2;
            end else begin
                if (tx_done) begin
                    m_phase = 0;
                    if (!m_lock) m_rr = (m_owner + 1) % N;
                end
            end
        end
    end

    // Per-cycle compare plus event bookkeeping for the directed checks.
    int           cyc = 0;
    int           last_acc_cyc = 0;
    int           last_en_cyc = 0;
    int           n_en = 0;
    int           lock_seen = 0;
    int           locked_idle = 0;
    int           rdy_busy = 0;
    logic         prev_lock = 1'b0;
    logic [N-1:0] drop_ready = '0;

    always @(negedge clk) begin
        logic [N-1:0] er;
        cyc++;
        er = model_ready();
        check("ready", 32'(req_ready), 32'(er));
        check("tx_en", 32'(tx_en), 32'(m_en));
        check("tx_data", 32'(tx_data), 32'(m_data));
        check("owner", 32'(owner), 32'(m_owner));
        check("lock", 32'(lock), 32'(m_lock));
        check("busy", 32'(busy), 32'(m_phase != 0 || m_lock));
        acc_idx = -1;
        for (int i = 0; i < N; i++) if (er[i] && req_valid[i]) acc_idx = i;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                dut_log.push_back({4'(i), req_data[8*i +: 8]});
                last_acc_cyc = cyc;
            end
        end
        if (tx_en) begin
            n_en++;
            last_en_cyc = cyc;
        end
        if (lock) lock_seen++;
        if (m_phase == 0 && m_lock) locked_idle++;
        if (req_ready != '0 && !tx_done) rdy_busy++;
        if (prev_lock && !lock) drop_ready = req_ready;
        prev_lock = lock;
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #3;
            n++;
        end while (!(pq.size() == 0 && m_phase == 0 && tx_cnt == 0 && !tx_pend) && n < 3000);
        check({name, "_drain"}, 32'(pq.size() == 0 && m_phase == 0), 32'd1);
    endtask

    task automatic verify_log(input string name);
        check({name, "_count"}, 32'(dut_log.size()), 32'(exp_q.size()));
        for (int i = checked; i < exp_q.size() && i < dut_log.size(); i++) begin
            check($sformatf("%s_entry%0d", name, i), 32'(dut_log[i]), 32'(exp_q[i]));
        end
        checked = exp_q.size();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int ld;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Round-robin from pointer 0: expected order 0,1,2,3,0.
        @(negedge clk);
        push(0, 1'b1, 8'h20); push(0, 1'b1, 8'h24);
        push(1, 1'b1, 8'h21); push(2, 1'b1, 8'h22); push(3, 1'b1, 8'h23);
        expect_byte(0, 8'h20); expect_byte(1, 8'h21); expect_byte(2, 8'h22);
        expect_byte(3, 8'h23); expect_byte(0, 8'h24);
        wait_drain("rr");
        verify_log("rr");

        // Packet lock: pointer now 1, req1 packet uninterrupted, then 3, then 0.
        @(negedge clk);
        push(1, 1'b0, 8'h10); push(1, 1'b0, 8'h11); push(1, 1'b1, 8'h12);
        push(0, 1'b1, 8'h30); push(3, 1'b1, 8'h33);
        expect_byte(1, 8'h10); expect_byte(1, 8'h11); expect_byte(1, 8'h12);
        expect_byte(3, 8'h33); expect_byte(0, 8'h30);
        wait_drain("lock");
        verify_log("lock");

        // Single byte from req 2.
        do_reset();
        lock_seen = 0;
        @(negedge clk);
        push(2, 1'b1, 8'h41);
        expect_byte(2, 8'h41);
        wait_drain("single");
        verify_log("single");
        check("single_en_latency", 32'(last_en_cyc - last_acc_cyc), 32'd1);
        check("single_lock_cycles", 32'(lock_seen), 32'd0);
        check("single_busy_end", 32'(busy), 32'd0);

        // Lock timeout: req0 leaves lock held, req2 waits for the release.
        do_reset();
        ld = locked_idle;
        @(negedge clk);
        push(0, 1'b0, 8'h60); push(2, 1'b1, 8'h62);
        expect_byte(0, 8'h60); expect_byte(2, 8'h62);
        wait_drain("timeout");
        verify_log("timeout");
        check("timeout_idle_cycles", 32'(locked_idle - ld), 32'd16);
        check("timeout_next_grant", 32'(drop_ready), 32'b0100);

        // done held low externally: no offer until it is released.
        @(posedge clk);
        #2 force_low = 1'b1;
        @(negedge clk);
        push(1, 1'b1, 8'h71);
        expect_byte(1, 8'h71);
        repeat (12) @(posedge clk);
        check("forced_no_accept", 32'(dut_log.size()), 32'(checked));
        #2 force_low = 1'b0;
        wait_drain("forced");
        verify_log("forced");

        // Reset while the transmitter is mid-frame.
        @(negedge clk);
        push(0, 1'b1, 8'h80); push(1, 1'b1, 8'h81);
        expect_byte(0, 8'h80); expect_byte(1, 8'h81);
        n = 0;
        do begin
            @(posedge clk);
            #3;
            n++;
        end while (m_phase != 2 && n < 200);
        check("midbyte_reach_wait_high", 32'(m_phase), 32'd2);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midbyte_rst_tx_en", 32'(tx_en), 32'd0);
        check("midbyte_rst_tx_data", 32'(tx_data), 32'd0);
        check("midbyte_rst_owner", 32'(owner), 32'd0);
        check("midbyte_rst_lock", 32'(lock), 32'd0);
        check("midbyte_rst_busy", 32'(busy), 32'd0);
        check("midbyte_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_drain("midbyte");
        verify_log("midbyte");

        repeat (4) @(posedge clk);
        check("tx_en_pulses", 32'(n_en), 32'd16);
        check("tx_overlap", 32'(tx_overlap), 32'd0);
        check("ready_while_done_low", 32'(rdy_busy), 32'd0);
        check("tx_byte_count", 32'(tx_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < tx_log.size() && i < exp_q.size(); i++) begin
            check($sformatf("tx_byte%0d", i), 32'(tx_log[i]), 32'(exp_q[i][7:0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
